register_bank_mux: RTL and testbench

- Parametrised register bank that stores NUM_REGS words of DATA_W bits and serves NUM_RD independent registered read ports.
- Each read port has a write-to-read bypass and out-of-range detection.
- A valid/ready dump engine streams every register in index order for debug and scan-out.
- The bank sits between the datapath write-back and the operand-fetch and debug logic, and replaces flat-bus register selection.

---
 rtl/register_bank_mux.sv | 141 ++++++++++++++
 tb/tb_register_bank_mux.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_mux.sv
// register_bank_mux: parametrised register bank with registered read ports,
// write-to-read bypass, out-of-range flagging and a valid/ready dump engine.
module register_bank_mux #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 64,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD-1:0]          rd_req,
    input  logic [NUM_RD*IDX_W-1:0]    rd_idx,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    output logic [NUM_RD-1:0]          rd_err,
    input  logic                       dump_start,
    output logic                       dump_busy,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [IDX_W-1:0]           dump_idx,
    output logic [DATA_W-1:0]          dump_data,
    output logic                       dump_last,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDX_W:0]   LIM  = (IDX_W+1)'(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_idx} < LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (wr_ok) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int r = 0; r < NUM_REGS; r++)
            regs_flat[r*DATA_W +: DATA_W] = regs[r];
    end

    // Read ports: unrequested ports keep their last data
    logic [NUM_RD*DATA_W-1:0] rd_data_d;
    logic [NUM_RD-1:0]        rd_err_d;

    always_comb begin
        rd_data_d = rd_data;
        rd_err_d  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_req[p]) begin
                if ({1'b0, rd_idx[p*IDX_W +: IDX_W]} >= LIM) begin
                    rd_data_d[p*DATA_W +: DATA_W] = '0;
                    rd_err_d[p] = 1'b1;
                end else if (wr_ok && wr_idx == rd_idx[p*IDX_W +: IDX_W]) begin
                    rd_data_d[p*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data_d[p*DATA_W +: DATA_W] = regs[rd_idx[p*IDX_W +: IDX_W]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= '0;
            rd_err   <= '0;
        end else begin
            rd_data  <= rd_data_d;
            rd_valid <= rd_req;
            rd_err   <= rd_err_d;
        end
    end

    // Dump engine
    state_t            state, state_d;
    logic              load;
    logic [IDX_W-1:0]  load_idx;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        state_d  = state;
        load     = 1'b0;
        load_idx = '0;
        unique case (state)
            IDLE: begin
                if (dump_start) begin
                    state_d = STREAM;
                    load    = 1'b1;
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    if (dump_idx == LAST) begin
                        state_d = IDLE;
                    end else begin
                        load     = 1'b1;
                        load_idx = dump_idx + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data is captured at load time so stalled beats stay stable
    always_comb begin
        load_data = regs[load_idx];
        if (wr_ok && wr_idx == load_idx) load_data = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dump_idx  <= '0;
            dump_data <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                dump_idx  <= load_idx;
                dump_data <= load_data;
            end
        end
    end

    assign dump_valid = (state == STREAM);
    assign dump_busy  = (state == STREAM);
    assign dump_last  = dump_valid && (dump_idx == LAST);

endmodule

// File: tb/tb_register_bank_mux.sv
// tb_register_bank_mux: randomized and directed checks of register_bank_mux
// against a behavioural bank model (64-entry and 40-entry builds).
module tb_register_bank_mux;

    localparam int DW  = 16;
    localparam int NR  = 64;
    localparam int NR2 = 40;
    localparam int IW  = 6;
    localparam int NP  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [DW-1:0]     wr_data;
    logic [NP-1:0]     rd_req;
    logic [NP*IW-1:0]  rd_idx;
    logic [NP*DW-1:0]  rd_data;
    logic [NP-1:0]     rd_valid, rd_err;
    logic              dump_start, dump_busy, dump_valid, dump_ready, dump_last;
    logic [IW-1:0]     dump_idx;
    logic [DW-1:0]     dump_data;
    logic [NR*DW-1:0]  regs_flat;

    logic              b_wr_en;
    logic [IW-1:0]     b_wr_idx;
    logic [DW-1:0]     b_wr_data;
    logic [NP-1:0]     b_rd_req;
    logic [NP*IW-1:0]  b_rd_idx;
    logic [NP*DW-1:0]  b_rd_data;
    logic [NP-1:0]     b_rd_valid, b_rd_err;
    logic              b_dump_start, b_dump_busy, b_dump_valid, b_dump_ready, b_dump_last;
    logic [IW-1:0]     b_dump_idx;
    logic [DW-1:0]     b_dump_data;
    logic [NR2*DW-1:0] b_regs_flat;

    register_bank_mux #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_err(rd_err),
        .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_last(dump_last), .regs_flat(regs_flat)
    );

    register_bank_mux #(.DATA_W(DW), .NUM_REGS(NR2), .NUM_RD(NP)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_data(b_wr_data),
        .rd_req(b_rd_req), .rd_idx(b_rd_idx), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .rd_err(b_rd_err),
        .dump_start(b_dump_start), .dump_busy(b_dump_busy),
        .dump_valid(b_dump_valid), .dump_ready(b_dump_ready),
        .dump_idx(b_dump_idx), .dump_data(b_dump_data),
        .dump_last(b_dump_last), .regs_flat(b_regs_flat)
    );

    // Behavioural model state
    logic [DW-1:0] mdl  [NR];
    logic [DW-1:0] mdl2 [NR2];
    logic [DW-1:0] ea_d [NP];
    logic [DW-1:0] eb_d [NP];
    bit            ea_v [NP], ea_e [NP], eb_v [NP], eb_e [NP];

    int checks = 0;
    int errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) mdl[r] = '0;
        for (int r = 0; r < NR2; r++) mdl2[r] = '0;
        for (int p = 0; p < NP; p++) begin
            ea_d[p] = '0;
            eb_d[p] = '0;
        end
    endtask

    // One clock: predict reads from pre-edge state, apply writes, compare
    task automatic tick();
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            logic [IW-1:0] i, j;
            i = rd_idx[p*IW +: IW];
            j = b_rd_idx[p*IW +: IW];
            ea_v[p] = rd_req[p];
            ea_e[p] = 1'b0;
            if (rd_req[p]) begin
                if (int'(i) >= NR) begin
                    ea_d[p] = '0;
                    ea_e[p] = 1'b1;
                end else if (wr_en && wr_idx == i) ea_d[p] = wr_data;
                else ea_d[p] = mdl[i];
            end
            eb_v[p] = b_rd_req[p];
            eb_e[p] = 1'b0;
            if (b_rd_req[p]) begin
                if (int'(j) >= NR2) begin
                    eb_d[p] = '0;
                    eb_e[p] = 1'b1;
                end else if (b_wr_en && b_wr_idx == j) eb_d[p] = b_wr_data;
                else eb_d[p] = mdl2[j];
            end
        end
        if (wr_en && int'(wr_idx) < NR) mdl[wr_idx] = wr_data;
        if (b_wr_en && int'(b_wr_idx) < NR2) mdl2[b_wr_idx] = b_wr_data;
        #1;
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rd_valid%0d", p), 32'(rd_valid[p]), 32'(ea_v[p]));
            check($sformatf("rd_data%0d", p), 32'(rd_data[p*DW +: DW]), 32'(ea_d[p]));
            check($sformatf("rd_err%0d", p), 32'(rd_err[p]), 32'(ea_e[p]));
            check($sformatf("b_rd_valid%0d", p), 32'(b_rd_valid[p]), 32'(eb_v[p]));
            check($sformatf("b_rd_data%0d", p), 32'(b_rd_data[p*DW +: DW]), 32'(eb_d[p]));
            check($sformatf("b_rd_err%0d", p), 32'(b_rd_err[p]), 32'(eb_e[p]));
        end
    endtask

    task automatic check_flat();
        for (int r = 0; r < NR; r++)
            check($sformatf("flat%0d", r), 32'(regs_flat[r*DW +: DW]), 32'(mdl[r]));
        for (int r = 0; r < NR2; r++)
            check($sformatf("b_flat%0d", r), 32'(b_regs_flat[r*DW +: DW]), 32'(mdl2[r]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_data"}, rd_data, 32'h0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
        check({tag, "_rd_err"}, 32'(rd_err), 32'h0);
        check({tag, "_b_rd_data"}, b_rd_data, 32'h0);
        check({tag, "_dump_busy"}, 32'(dump_busy), 32'h0);
        check({tag, "_dump_valid"}, 32'(dump_valid), 32'h0);
        check({tag, "_dump_last"}, 32'(dump_last), 32'h0);
        check({tag, "_dump_idx"}, 32'(dump_idx), 32'h0);
        check({tag, "_dump_data"}, 32'(dump_data), 32'h0);
    endtask

    function automatic logic [DW-1:0] dump_exp(input int b);
        return (b == 31) ? 16'hA5A5 : DW'(b * 3);
    endfunction

    initial begin
        int beat, cyc, n;
        bit stall_wr, byp_wr, restart;
        logic hs;

        rst_n = 1'b0;
        wr_en = 0; wr_idx = '0; wr_data = '0; rd_req = '0; rd_idx = '0;
        dump_start = 0; dump_ready = 0;
        b_wr_en = 0; b_wr_idx = '0; b_wr_data = '0; b_rd_req = '0; b_rd_idx = '0;
        b_dump_start = 0; b_dump_ready = 0;
        model_reset();

        #12;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_flat();

        // Every index reads zero after reset, one valid per request
        for (int i = 0; i < NR; i++) begin
            rd_req = 2'b01;
            rd_idx = {IW'(0), IW'(i)};
            tick();
        end
        rd_req = '0;

        wr_en = 1; wr_idx = 6'd5; wr_data = 16'hBEEF;
        tick();
        wr_en = 0;
        rd_req = 2'b11;
        rd_idx = {6'd5, 6'd5};
        tick();
        check("beef_p0", 32'(rd_data[0 +: DW]), 32'hBEEF);
        check("beef_p1", 32'(rd_data[DW +: DW]), 32'hBEEF);

        wr_en = 1; wr_idx = 6'd12; wr_data = 16'h1234;
        rd_req = 2'b10;
        rd_idx = {6'd12, 6'd0};
        tick();
        check("bypass_p1", 32'(rd_data[DW +: DW]), 32'h1234);
        wr_en = 0; rd_req = '0;
        tick();

        // 40-entry build: out-of-range read and dropped write
        b_rd_req = 2'b01;
        b_rd_idx = {6'd0, 6'd45};
        tick();
        check("b_oor_err", 32'(b_rd_err[0]), 32'h1);
        check("b_oor_valid", 32'(b_rd_valid[0]), 32'h1);
        check("b_oor_data", 32'(b_rd_data[0 +: DW]), 32'h0);
        b_rd_req = '0;
        b_wr_en = 1; b_wr_idx = 6'd45; b_wr_data = 16'h1111;
        tick();
        b_wr_en = 0;
        check_flat();

        for (int k = 0; k < 400; k++) begin
            wr_en   = 1'($urandom);
            wr_idx  = IW'($urandom);
            wr_data = DW'($urandom);
            rd_req  = NP'($urandom);
            rd_idx  = (NP*IW)'($urandom);
            if ($urandom_range(3) == 0) rd_idx[IW-1:0] = wr_idx;
            b_wr_en   = 1'($urandom);
            b_wr_idx  = IW'($urandom);
            b_wr_data = DW'($urandom);
            b_rd_req  = NP'($urandom);
            b_rd_idx  = (NP*IW)'($urandom);
            if ($urandom_range(3) == 0) b_rd_idx[IW +: IW] = b_wr_idx;
            tick();
        end
        wr_en = 0; rd_req = '0; b_wr_en = 0; b_rd_req = '0;
        tick();
        check_flat();

        for (int i = 0; i < NR; i++) begin
            wr_en = 1; wr_idx = IW'(i); wr_data = DW'(i * 3);
            tick();
        end
        wr_en = 0;

        dump_start = 1;
        tick();
        dump_start = 0;
        beat = 0; cyc = 0; stall_wr = 0; byp_wr = 0; restart = 0;
        while (beat < NR && cyc < 1000) begin
            dump_ready = (cyc % 3 == 0);
            check("dump_valid", 32'(dump_valid), 32'h1);
            check("dump_busy", 32'(dump_busy), 32'h1);
            check("dump_idx", 32'(dump_idx), 32'(beat));
            check("dump_data", 32'(dump_data), 32'(dump_exp(beat)));
            check("dump_last", 32'(dump_last), 32'(beat == NR - 1));
            if (beat == 10 && !dump_ready && !stall_wr) begin
                stall_wr = 1;
                wr_en = 1; wr_idx = 6'd10; wr_data = 16'hFFFF;
            end
            if (beat == 30 && dump_ready && !byp_wr) begin
                byp_wr = 1;
                wr_en = 1; wr_idx = 6'd31; wr_data = 16'hA5A5;
            end
            if (beat == 20 && !restart) begin
                restart = 1;
                dump_start = 1;
            end
            hs = dump_valid && dump_ready;
            tick();
            wr_en = 0; dump_start = 0;
            if (hs) beat++;
            cyc++;
        end
        check("dump_beats", 32'(beat), 32'(NR));
        check("dump_end_valid", 32'(dump_valid), 32'h0);
        check("dump_end_busy", 32'(dump_busy), 32'h0);
        check("dump_end_last", 32'(dump_last), 32'h0);
        dump_ready = 0;
        tick();
        check("dump_idle_busy", 32'(dump_busy), 32'h0);
        check_flat();

        // Reset mid-dump with a write to reg[3] pending
        dump_start = 1;
        tick();
        dump_start = 0;
        dump_ready = 1;
        n = 0;
        while (dump_idx != 6'd20 && n < 200) begin
            tick();
            n++;
        end
        check("dump_reach20", 32'(dump_idx), 32'd20);
        wr_en = 1; wr_idx = 6'd3; wr_data = 16'h7777;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("midreset");
        check_flat();
        wr_en = 0; dump_ready = 0;
        @(posedge clk);
        #1;
        check_zero("midreset_hold");
        rst_n = 1'b1;
        dump_start = 1;
        tick();
        dump_start = 0;
        check("restart_valid", 32'(dump_valid), 32'h1);
        check("restart_idx", 32'(dump_idx), 32'h0);
        check("restart_data", 32'(dump_data), 32'h0);
        check_flat();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
